// File: rtl/ghash_pkg.sv
// Shared types and constants for the GHASH sequencer.
//   BLK_W / LEN_W : block and length-block width
//   MUL_LAT       : split_multiplier latency, a_i presentation to valid mul_o
//   CNT_W         : width of the multiplier wait counter
package ghash_pkg;

  localparam int unsigned BLK_W   = 128;
  localparam int unsigned LEN_W   = 128;
  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned CNT_W   = $clog2(MUL_LAT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_LEN_ISSUE,
    ST_LEN_WAIT,
    ST_DONE
  } ghash_state_e;

endpackage

// File: rtl/ghash_ctrl_if.sv
// Block stream into the GHASH sequencer (valid/ready with last marker).
//   blk_valid_i : source has a block
//   blk_ready_o : sequencer can take a block this cycle
//   blk_data_i  : 128-bit padded AAD/ciphertext block
//   blk_last_i  : final data block of the message
interface ghash_ctrl_if;
  import ghash_pkg::*;

  logic             blk_valid_i;
  logic             blk_ready_o;
  logic [BLK_W-1:0] blk_data_i;
  logic             blk_last_i;

  modport master (output blk_valid_i, blk_data_i, blk_last_i, input blk_ready_o);
  modport slave  (input blk_valid_i, blk_data_i, blk_last_i, output blk_ready_o);

endinterface

// File: rtl/ghash_ctrl.sv
// GHASH sequencer: folds each accepted block into Y <= (Y ^ X) * H through the
// external 4-stage split_multiplier, then issues len(A)||len(C) and presents the tag.
//   clk, rst_n         : clock, async active-low reset
//   start_i            : begin new hash (IDLE only); samples h_i, empty_i (and len_i if empty)
//   h_i, empty_i, len_i: hash key, no-data flag, length block
//   blk                : block stream (slave side)
//   tag_valid_o, tag_o : one-cycle tag strobe, held tag
//   busy_o             : not IDLE
//   mul_h[a-d]_o       : H slices to the multiplier
//   mul_a_o, mul_rst_o : multiplier operand and active-high reset
//   mul_i              : multiplier result
module ghash_ctrl
  import ghash_pkg::*;
#(
  parameter int unsigned DATA__WIDTH = BLK_W,
  parameter int unsigned SPLIT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [DATA__WIDTH-1:0] h_i,
  input  logic                   empty_i,
  input  logic [DATA__WIDTH-1:0] len_i,
  ghash_ctrl_if.slave            blk,
  output logic                   tag_valid_o,
  output logic [DATA__WIDTH-1:0] tag_o,
  output logic                   busy_o,
  output logic [SPLIT_WIDTH-1:0] mul_ha_o,
  output logic [SPLIT_WIDTH-1:0] mul_hb_o,
  output logic [SPLIT_WIDTH-1:0] mul_hc_o,
  output logic [SPLIT_WIDTH-1:0] mul_hd_o,
  output logic [DATA__WIDTH-1:0] mul_a_o,
  output logic                   mul_rst_o,
  input  logic [DATA__WIDTH-1:0] mul_i
);

  ghash_state_e r_state, w_state_nxt;

  logic [DATA__WIDTH-1:0] r_y;
  logic [DATA__WIDTH-1:0] r_h;
  logic [DATA__WIDTH-1:0] r_len;
  logic [DATA__WIDTH-1:0] r_tag;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_last;
  logic                   r_mul_rst;

  logic                   w_start;
  logic                   w_blk_hs;
  logic                   w_waiting;
  logic                   w_cnt_done;
  logic [DATA__WIDTH-1:0] w_mul_a;

  assign w_start    = (r_state == ST_IDLE) && start_i;
  assign w_blk_hs   = (r_state == ST_ISSUE) && blk.blk_valid_i;
  assign w_waiting  = (r_state == ST_WAIT) || (r_state == ST_LEN_WAIT);
  assign w_cnt_done = (r_cnt == CNT_W'(MUL_LAT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and multiplier operand
  always_comb begin
    w_state_nxt = r_state;
    w_mul_a     = '0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) w_state_nxt = empty_i ? ST_LEN_ISSUE : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (blk.blk_valid_i) begin
          w_mul_a     = r_y ^ blk.blk_data_i;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_cnt_done) w_state_nxt = r_last ? ST_LEN_ISSUE : ST_ISSUE;
      end
      ST_LEN_ISSUE: begin
        w_mul_a     = r_y ^ r_len;
        w_state_nxt = ST_LEN_WAIT;
      end
      ST_LEN_WAIT: begin
        if (w_cnt_done) w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Hash datapath: key/length latches, wait counter, running Y and tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y       <= '0;
      r_h       <= '0;
      r_len     <= '0;
      r_tag     <= '0;
      r_cnt     <= '0;
      r_last    <= 1'b0;
      r_mul_rst <= 1'b1;
    end else begin
      r_mul_rst <= 1'b0;
      if (w_start) begin
        r_h <= h_i;
        r_y <= '0;
        if (empty_i) r_len <= len_i;
      end
      if (w_blk_hs) begin
        r_last <= blk.blk_last_i;
        if (blk.blk_last_i) r_len <= len_i;
      end
      // Counter sits at 0 outside the wait states, so every wait starts from 0
      if (w_waiting) r_cnt <= r_cnt + CNT_W'(1);
      else           r_cnt <= '0;
      if (w_waiting && w_cnt_done) begin
        r_y <= mul_i;
        if (r_state == ST_LEN_WAIT) r_tag <= mul_i;
      end
    end
  end

  assign blk.blk_ready_o = (r_state == ST_ISSUE);
  assign tag_valid_o     = (r_state == ST_DONE);
  assign busy_o          = (r_state != ST_IDLE);
  assign tag_o           = r_tag;
  assign mul_a_o         = w_mul_a;
  // Flush the multiplier pipeline in the start cycle so the first issue lands clean
  assign mul_rst_o       = r_mul_rst | w_start;

  assign mul_ha_o = r_h[DATA__WIDTH-1 -: SPLIT_WIDTH];
  assign mul_hb_o = r_h[DATA__WIDTH-SPLIT_WIDTH-1 -: SPLIT_WIDTH];
  assign mul_hc_o = r_h[2*SPLIT_WIDTH-1 -: SPLIT_WIDTH];
  assign mul_hd_o = r_h[SPLIT_WIDTH-1:0];

endmodule

// File: tb/tb_ghash_ctrl.sv
module tb_ghash_ctrl;

  logic         clk;
  logic         rst_n;
  logic         start_i;
  logic [127:0] h_i;
  logic         empty_i;
  logic [127:0] len_i;
  logic         tag_valid_o;
  logic [127:0] tag_o;
  logic         busy_o;
  logic [31:0]  mul_ha_o, mul_hb_o, mul_hc_o, mul_hd_o;
  logic [127:0] mul_a_o;
  logic         mul_rst_o;
  logic [127:0] mul_i;

  ghash_ctrl_if u_if ();

  ghash_ctrl u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .h_i         (h_i),
    .empty_i     (empty_i),
    .len_i       (len_i),
    .blk         (u_if),
    .tag_valid_o (tag_valid_o),
    .tag_o       (tag_o),
    .busy_o      (busy_o),
    .mul_ha_o    (mul_ha_o),
    .mul_hb_o    (mul_hb_o),
    .mul_hc_o    (mul_hc_o),
    .mul_hd_o    (mul_hd_o),
    .mul_a_o     (mul_a_o),
    .mul_rst_o   (mul_rst_o),
    .mul_i       (mul_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] ID   = 128'h80000000_00000000_00000000_00000000;
  localparam logic [127:0] JUNK = 128'hdeadbeef_cafef00d_01020304_a5a5a5a5;
  localparam logic [127:0] GH   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] GC   = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] GT   = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;

  int total;
  int bad;

  // Behavioural stand-in for split_multiplier: GF(2^128) product, 4 register stages
  function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z;
    logic [127:0] v;
    z = '0;
    v = y;
    for (int i = 127; i >= 0; i--) begin
      if (x[i]) z = z ^ v;
      if (v[0]) v = (v >> 1) ^ {8'he1, 120'h0};
      else      v = v >> 1;
    end
    return z;
  endfunction

  logic [127:0] m_s0, m_s1, m_s2, m_s3;
  always @(posedge clk) begin
    if (mul_rst_o) begin
      m_s0 <= '0; m_s1 <= '0; m_s2 <= '0; m_s3 <= '0;
    end else begin
      m_s0 <= gf_mul(mul_a_o, {mul_ha_o, mul_hb_o, mul_hc_o, mul_hd_o});
      m_s1 <= m_s0;
      m_s2 <= m_s1;
      m_s3 <= m_s2;
    end
  end
  assign mul_i = m_s3;

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_blk(input logic v, input logic [127:0] d, input logic l, input logic [127:0] len);
    u_if.blk_valid_i = v;
    u_if.blk_data_i  = d;
    u_if.blk_last_i  = l;
    len_i            = len;
  endtask

  task automatic do_start(input logic [127:0] h, input logic e, input logic [127:0] len);
    next_cyc();
    start_i = 1'b1;
    h_i     = h;
    empty_i = e;
    len_i   = len;
    drive_blk(1'b0, JUNK, 1'b0, len);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (u_if.blk_ready_o !== 1'b0) begin bad++; $display("FAIL rst ready got %b exp 0", u_if.blk_ready_o); end
    total++; if (tag_valid_o !== 1'b0) begin bad++; $display("FAIL rst tag_valid got %b exp 0", tag_valid_o); end
    total++; if (tag_o !== '0) begin bad++; $display("FAIL rst tag got %h exp 0", tag_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst busy got %b exp 0", busy_o); end
    total++; if (mul_a_o !== '0) begin bad++; $display("FAIL rst mul_a got %h exp 0", mul_a_o); end
    total++; if (mul_rst_o !== 1'b1) begin bad++; $display("FAIL rst mul_rst got %b exp 1", mul_rst_o); end
    rst_n = 1'b1;
    #1;
    total++; if (mul_rst_o !== 1'b1) begin bad++; $display("FAIL rst mul_rst_hold got %b exp 1", mul_rst_o); end
    next_cyc();
    total++; if (mul_rst_o !== 1'b0) begin bad++; $display("FAIL rst mul_rst_release got %b exp 0", mul_rst_o); end
  endtask

  task automatic test_identity_one_block();
    logic [127:0] x, l, exp_a;
    x = 128'h0123456789abcdef0123456789abcdef;
    l = 128'h80;
    do_start(ID, 1'b0, JUNK);
    @(negedge clk);
    total++; if (mul_rst_o !== 1'b1) begin bad++; $display("FAIL one flush got %b exp 1", mul_rst_o); end
    for (int c = 1; c <= 12; c++) begin
      next_cyc();
      start_i = 1'b0;
      if (c == 1) drive_blk(1'b1, x, 1'b1, l);
      else        drive_blk(1'b0, JUNK, 1'b0, JUNK);
      @(negedge clk);
      exp_a = (c == 1) ? x : ((c == 6) ? (x ^ l) : '0);
      total++; if (u_if.blk_ready_o !== (c == 1)) begin bad++; $display("FAIL one ready c=%0d got %b", c, u_if.blk_ready_o); end
      total++; if (mul_a_o !== exp_a) begin bad++; $display("FAIL one mul_a c=%0d got %h exp %h", c, mul_a_o, exp_a); end
      total++; if (tag_valid_o !== (c == 11)) begin bad++; $display("FAIL one tag_valid c=%0d got %b", c, tag_valid_o); end
      total++; if (busy_o !== (c <= 11)) begin bad++; $display("FAIL one busy c=%0d got %b", c, busy_o); end
      if (c >= 11) begin
        total++; if (tag_o !== 128'h0123456789abcdef0123456789abcd6f) begin bad++; $display("FAIL one tag c=%0d got %h exp %h", c, tag_o, 128'h0123456789abcdef0123456789abcd6f); end
      end
    end
  endtask

  task automatic test_gcm_vector();
    do_start(GH, 1'b0, JUNK);
    for (int c = 1; c <= 11; c++) begin
      next_cyc();
      start_i = 1'b0;
      if (c == 1) drive_blk(1'b1, GC, 1'b1, 128'h80);
      else        drive_blk(1'b0, JUNK, 1'b0, JUNK);
      @(negedge clk);
      if (c == 1) begin
        total++; if ({mul_ha_o, mul_hb_o, mul_hc_o, mul_hd_o} !== GH) begin bad++; $display("FAIL gcm h_slices got %h exp %h", {mul_ha_o, mul_hb_o, mul_hc_o, mul_hd_o}, GH); end
      end
      if (c >= 10) begin
        total++; if (tag_valid_o !== (c == 11)) begin bad++; $display("FAIL gcm tag_valid c=%0d got %b", c, tag_valid_o); end
      end
    end
    total++; if (tag_o !== GT) begin bad++; $display("FAIL gcm tag got %h exp %h", tag_o, GT); end
  endtask

  task automatic test_empty();
    do_start(ID, 1'b1, 128'h0);
    @(negedge clk);
    total++; if (mul_rst_o !== 1'b1) begin bad++; $display("FAIL empty flush got %b exp 1", mul_rst_o); end
    for (int c = 1; c <= 7; c++) begin
      next_cyc();
      start_i = 1'b0;
      drive_blk(1'b1, JUNK, 1'b1, JUNK);
      @(negedge clk);
      total++; if (u_if.blk_ready_o !== 1'b0) begin bad++; $display("FAIL empty ready c=%0d got %b exp 0", c, u_if.blk_ready_o); end
      total++; if (tag_valid_o !== (c == 6)) begin bad++; $display("FAIL empty tag_valid c=%0d got %b", c, tag_valid_o); end
      if (c == 6) begin
        total++; if (tag_o !== '0) begin bad++; $display("FAIL empty tag got %h exp 0", tag_o); end
      end
    end
    drive_blk(1'b0, JUNK, 1'b0, JUNK);
  endtask

  task automatic test_back_to_back();
    logic [127:0] a, b, cc, l, exp_a, d;
    logic v, lst;
    a  = 128'h11112222333344445555666677778888;
    b  = 128'h0f0e0d0c0b0a09080706050403020100;
    cc = 128'hfedcba98765432100123456789abcdef;
    l  = 128'h00000000000001800000000000000200;
    do_start(ID, 1'b0, JUNK);
    for (int c = 1; c <= 22; c++) begin
      next_cyc();
      start_i = 1'b0;
      v = 1'b0; d = JUNK; lst = 1'b0;
      if (c == 1)                begin v = 1'b1; d = a;  end
      else if (c >= 3 && c <= 6)  begin v = 1'b1; d = b;  end
      else if (c >= 8 && c <= 11) begin v = 1'b1; d = cc; lst = 1'b1; end
      drive_blk(v, d, lst, (c == 11) ? l : JUNK);
      @(negedge clk);
      case (c)
        1:       exp_a = a;
        6:       exp_a = a ^ b;
        11:      exp_a = a ^ b ^ cc;
        16:      exp_a = a ^ b ^ cc ^ l;
        default: exp_a = '0;
      endcase
      total++; if (u_if.blk_ready_o !== (c == 1 || c == 6 || c == 11)) begin bad++; $display("FAIL b2b ready c=%0d got %b", c, u_if.blk_ready_o); end
      total++; if (mul_a_o !== exp_a) begin bad++; $display("FAIL b2b mul_a c=%0d got %h exp %h", c, mul_a_o, exp_a); end
      total++; if (tag_valid_o !== (c == 21)) begin bad++; $display("FAIL b2b tag_valid c=%0d got %b", c, tag_valid_o); end
    end
    total++; if (tag_o !== (a ^ b ^ cc ^ l)) begin bad++; $display("FAIL b2b tag got %h exp %h", tag_o, a ^ b ^ cc ^ l); end
  endtask

  task automatic test_reset_len_wait();
    logic [127:0] x, e, l2;
    x  = 128'h55555555aaaaaaaa55555555aaaaaaaa;
    e  = 128'h00112233445566778899aabbccddeeff;
    l2 = 128'h00000000000000400000000000000100;
    do_start(GH, 1'b0, JUNK);
    for (int c = 1; c <= 7; c++) begin
      next_cyc();
      start_i = 1'b0;
      if (c == 1) drive_blk(1'b1, x, 1'b1, 128'h80);
      else        drive_blk(1'b0, JUNK, 1'b0, JUNK);
    end
    next_cyc();
    rst_n = 1'b0;
    #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL abort busy got %b exp 0", busy_o); end
    total++; if (tag_o !== '0) begin bad++; $display("FAIL abort tag got %h exp 0", tag_o); end
    total++; if (mul_rst_o !== 1'b1) begin bad++; $display("FAIL abort mul_rst got %b exp 1", mul_rst_o); end
    total++; if (mul_a_o !== '0) begin bad++; $display("FAIL abort mul_a got %h exp 0", mul_a_o); end
    total++; if ({mul_ha_o, mul_hb_o, mul_hc_o, mul_hd_o} !== '0) begin bad++; $display("FAIL abort h_slices got %h exp 0", {mul_ha_o, mul_hb_o, mul_hc_o, mul_hd_o}); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++; if (tag_valid_o !== 1'b0) begin bad++; $display("FAIL abort tag_valid k=%0d got %b exp 0", c, tag_valid_o); end
    end
    next_cyc();
    rst_n = 1'b1;
    do_start(ID, 1'b0, JUNK);
    for (int c = 1; c <= 11; c++) begin
      next_cyc();
      start_i = 1'b0;
      if (c == 1) drive_blk(1'b1, e, 1'b1, l2);
      else        drive_blk(1'b0, JUNK, 1'b0, JUNK);
      @(negedge clk);
      if (c == 11) begin
        total++; if (tag_valid_o !== 1'b1) begin bad++; $display("FAIL rehash tag_valid got %b exp 1", tag_valid_o); end
        total++; if (tag_o !== (e ^ l2)) begin bad++; $display("FAIL rehash tag got %h exp %h", tag_o, e ^ l2); end
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [127:0] x, l;
    x = 128'h89abcdef0123456789abcdef01234567;
    l = 128'h00000000000000000000000000000080;
    do_start(ID, 1'b0, JUNK);
    for (int c = 1; c <= 12; c++) begin
      next_cyc();
      start_i = 1'b0;
      h_i     = ID;
      empty_i = 1'b0;
      if (c == 1)      drive_blk(1'b1, x, 1'b1, l);
      else             drive_blk(1'b0, JUNK, 1'b0, JUNK);
      if (c == 3) begin
        start_i = 1'b1;
        h_i     = GH;
        empty_i = 1'b1;
      end
      @(negedge clk);
      if (c == 3) begin
        total++; if (mul_rst_o !== 1'b0) begin bad++; $display("FAIL ign mul_rst got %b exp 0", mul_rst_o); end
      end
      if (c == 4) begin
        total++; if ({mul_ha_o, mul_hb_o, mul_hc_o, mul_hd_o} !== ID) begin bad++; $display("FAIL ign h_slices got %h exp %h", {mul_ha_o, mul_hb_o, mul_hc_o, mul_hd_o}, ID); end
      end
      total++; if (tag_valid_o !== (c == 11)) begin bad++; $display("FAIL ign tag_valid c=%0d got %b", c, tag_valid_o); end
    end
    total++; if (tag_o !== (x ^ l)) begin bad++; $display("FAIL ign tag got %h exp %h", tag_o, x ^ l); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL ign busy_end got %b exp 0", busy_o); end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    start_i = 1'b0;
    h_i     = '0;
    empty_i = 1'b0;
    len_i   = '0;
    u_if.blk_valid_i = 1'b0;
    u_if.blk_data_i  = '0;
    u_if.blk_last_i  = 1'b0;
    test_reset();
    test_identity_one_block();
    test_gcm_vector();
    test_empty();
    test_back_to_back();
    test_reset_len_wait();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ghash_ctrl.md
Name: ghash_ctrl

Overview:
- Sequences one GHASH computation over the 4-stage pipelined split GF(2^128) multiplier (split_multiplier).
- Accepts 128-bit blocks over a valid/ready stream and folds each into the running hash: Y <= (Y ^ X) * H.
- Issues the final len(A)||len(C) block, then presents the 128-bit tag.
- Sits between the AES-CTR block stream and the multiplier; owns the multiplier's a_i and H-slice inputs.

Parameters:
- DATA__WIDTH, 128: block/hash width.
- SPLIT_WIDTH, 32: H slice width; DATA__WIDTH/SPLIT_WIDTH must equal 4.
- MUL_LAT, 4: multiplier latency in cycles from a_i presentation to valid mul_o.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  pulse; begins a new hash, clears Y, samples h_i and empty_i.
- h_i  in  128  hash key H, sampled on accepted start_i.
- empty_i  in  1  sampled with start_i; 1 = message has no data blocks (length block only).
- len_i  in  128  len(A)||len(C); sampled on the last-block handshake, or on start_i when empty_i=1.
- blk_valid_i  in  1  input block valid.
- blk_ready_o  out  1  ready to accept a block.
- blk_data_i  in  128  input block (AAD or ciphertext, padded).
- blk_last_i  in  1  marks the final data block.
- tag_valid_o  out  1  one-cycle pulse: tag_o valid.
- tag_o  out  128  GHASH result; held until the next accepted start_i.
- busy_o  out  1  high in every state except IDLE.
- mul_ha_o, mul_hb_o, mul_hc_o, mul_hd_o  out  32 each  H[127:96], H[95:64], H[63:32], H[31:0] from the latched H register.
- mul_a_o  out  128  multiplier operand.
- mul_rst_o  out  1  active-high multiplier reset.
- mul_i  in  128  multiplier result (mul_o).

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: state=IDLE, Y=0, H=0, len=0, cnt=0, blk_ready_o=0, tag_valid_o=0, tag_o=0, busy_o=0, mul_a_o=0, mul_rst_o=1.
  - mul_rst_o is a registered 1 and deasserts on the first clk edge after rst_n rises.
  - Reset mid-operation aborts the hash; no tag is emitted.
- States: IDLE, ISSUE, WAIT, LEN_ISSUE, LEN_WAIT, DONE.
- IDLE:
  - start_i=1: latch H, Y<=0, drive mul_rst_o=1 for one cycle (pipeline flush).
  - Next state is LEN_ISSUE if empty_i=1 (latch len_i), else ISSUE.
  - start_i while not IDLE is ignored.
- ISSUE:
  - blk_ready_o=1 combinationally; mul_a_o = Y ^ blk_data_i when blk_valid_i=1, else 0.
  - On handshake: remember blk_last_i, latch len_i if last, cnt<=0, go to WAIT.
- WAIT:
  - mul_a_o=0, blk_ready_o=0; cnt increments each cycle.
  - At cnt==MUL_LAT-1, Y<=mul_i.
  - Then go to LEN_ISSUE if the block was last, else ISSUE.
- LEN_ISSUE: mul_a_o = Y ^ len for exactly one cycle, cnt<=0, go to LEN_WAIT.
- LEN_WAIT: same as WAIT; captures Y<=mul_i at cnt==MUL_LAT-1, then tag_o<=mul_i and go to DONE.
- DONE: tag_valid_o=1 for this single cycle, then IDLE. tag_o holds.
- Timing (block accepted in cycle t):
  - Y updates at the end of cycle t+4; next ISSUE is cycle t+5, giving 5-cycle block throughput.
  - Last block accepted at t: LEN_ISSUE at t+5, tag_valid_o at t+10.
  - Empty message, start at t: LEN_ISSUE at t+1, tag_valid_o at t+6.
- mul_a_o is 0 outside issue cycles. Each multiplier slot is independent, so idle slots do not corrupt results.
- No back-pressure on the tag: the consumer must take it in the DONE cycle or read the held tag_o later.

Decomposition:
- ghash_pkg: state enum (ghash_state_e), MUL_LAT, BLK_W=128, LEN_W=128.
- Sub-module: none required. split_multiplier is instantiated by the parent; ghash_ctrl only connects to its ports.

Test Plan:
- H=0x8000...0 (GF identity), one block X=0x0123...cdef, len=0x...0080 -> tag = X ^ len; blk_ready_o high at t and t+5 only; tag_valid_o at t+10.
- H=0x66e94bd4ef8a2c3b884cfa59ca342b2e, block 0x0388dace60b6a392f328c2b971b2fe78 (last), len=0x0000000000000000_0000000000000080 -> tag 0xf38cbb1ad69223dcc3457ae5b6b0f885.
- Empty message, start_i with empty_i=1, H=identity, len=0 -> tag 0; tag_valid_o exactly 6 cycles after start.
- Three identity-H blocks A,B,C with blk_valid_i gapped 2 cycles each -> tag = A^B^C^len; no block accepted while busy in WAIT; mul_a_o=0 in all non-issue cycles.
- rst_n pulled low in LEN_WAIT -> all outputs return to reset values immediately, with no tag_valid_o; a new start_i afterwards computes a correct tag (Y cleared).
- start_i pulsed during WAIT -> ignored; H unchanged; the in-flight hash completes with the correct tag.
